// File: rtl/alu_wb_router_if.sv
// alu_wb_router_if
//   Bundles the write-back router's bus signals: the ALU beat input with its
//   ready, the RF write strobe port, the DM request/ack port, and the
//   error/drop status.
//   slave  : the router side (takes ALU beats, drives RF/DM/status).
//   master : the environment side (drives ALU beats, DM ack, err clear).
interface alu_wb_router_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] alu_result;
  logic [1:0]        alu_dst;
  logic [ADDR_W-1:0] alu_addr;
  logic              alu_valid;
  logic              alu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_data;
  logic              dm_ack;
  logic              err;
  logic              err_clr;
  logic [7:0]        drop_cnt;

  modport slave (
    input  alu_result, alu_dst, alu_addr, alu_valid, dm_ack, err_clr,
    output alu_ready, rf_we, rf_addr, rf_data, dm_req, dm_addr, dm_data,
           err, drop_cnt
  );

  modport master (
    output alu_result, alu_dst, alu_addr, alu_valid, dm_ack, err_clr,
    input  alu_ready, rf_we, rf_addr, rf_data, dm_req, dm_addr, dm_data,
           err, drop_cnt
  );
endinterface

// File: rtl/alu_wb_router.sv
// alu_wb_router
//   Write-back router. Accepts one ALU result per beat and routes it by
//   destination code: 00 -> register file (single-cycle write strobe),
//   11 -> data memory (req/ack handshake with timeout), 01/10 -> dropped
//   and counted in a saturating 8-bit counter.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : alu_wb_router_if.slave
//            alu_result/alu_dst/alu_addr/alu_valid/alu_ready : beat input
//            rf_we/rf_addr/rf_data                           : RF write port
//            dm_req/dm_addr/dm_data/dm_ack                   : DM write port
//            err (sticky DM timeout) / err_clr, drop_cnt     : status
module alu_wb_router #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int DM_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  alu_wb_router_if.slave bus
);
  localparam int CNT_W = (DM_TIMEOUT > 2) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_RF, WR_DM} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] rf_addr_q, dm_addr_q;
  logic [DATA_W-1:0] rf_data_q, dm_data_q;
  logic              err_q;
  logic [7:0]        drop_q;

  logic accept, acc_rf, acc_dm, acc_drop, timeout;
  logic ready, rf_we, dm_req;

  assign accept   = bus.alu_valid & ready;
  assign acc_rf   = accept & (bus.alu_dst == 2'b00);
  assign acc_dm   = accept & (bus.alu_dst == 2'b11);
  assign acc_drop = accept & (bus.alu_dst[1] ^ bus.alu_dst[0]);

  // Next state and state-decoded outputs. In WR_DM an ack beats the
  // timeout when both land on the same edge.
  always_comb begin
    state_nx = state;
    ready    = 1'b1;
    rf_we    = 1'b0;
    dm_req   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE, WR_RF: begin
        rf_we = (state == WR_RF);
        if (acc_rf)      state_nx = WR_RF;
        else if (acc_dm) state_nx = WR_DM;
        else             state_nx = IDLE;
      end
      WR_DM: begin
        ready  = 1'b0;
        dm_req = 1'b1;
        if (bus.dm_ack) state_nx = IDLE;
        else if (tmo_cnt == CNT_LAST) begin
          state_nx = IDLE;
          timeout  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Timeout counter restarts on every DM accept; it only advances while
  // waiting in WR_DM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (acc_dm)         tmo_cnt <= '0;
    else if (state == WR_DM) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Separate RF and DM capture registers so each port holds its own last
  // value regardless of what the other destination did since.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_addr_q <= '0;
      rf_data_q <= '0;
      dm_addr_q <= '0;
      dm_data_q <= '0;
    end else begin
      if (acc_rf) begin
        rf_addr_q <= bus.alu_addr;
        rf_data_q <= bus.alu_result;
      end
      if (acc_dm) begin
        dm_addr_q <= bus.alu_addr;
        dm_data_q <= bus.alu_result;
      end
    end
  end

  // Sticky error: a timeout on the same edge as a clear still sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_q <= 1'b0;
    else if (timeout)     err_q <= 1'b1;
    else if (bus.err_clr) err_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_q <= '0;
    else if (acc_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign bus.alu_ready = ready;
  assign bus.rf_we     = rf_we;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.dm_req    = dm_req;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.dm_data   = dm_data_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_alu_wb_router.sv
// tb_alu_wb_router
//   Self-checking bench for alu_wb_router. Inputs change 2 time units after
//   each rising edge; the main thread checks state-decoded outputs at that
//   point and a monitor compares RF/DM writes against a queue of expected
//   writes at each falling edge.
module tb_alu_wb_router;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int TMO    = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]        dst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              exp_we;
    logic              exp_req;
    logic [7:0]        exp_drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rf_seen = 0;
  wr_t  rf_q[$];
  wr_t  dm_q[$];
  wr_t  mon_e;
  vec_t vecs[6];

  alu_wb_router_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_wb_router #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DM_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input logic [1:0] dst, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    bus.alu_valid  = 1'b1;
    bus.alu_dst    = dst;
    bus.alu_addr   = a;
    bus.alu_result = d;
  endtask

  // Write scoreboard: every RF strobe and every acknowledged DM request
  // must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rf_we) begin
        rf_seen++;
        if (rf_q.size() == 0) chk("rf_unexpected_write", 32'd1, 32'd0);
        else begin
          mon_e = rf_q.pop_front();
          chk("rf_addr", 32'(bus.rf_addr), 32'(mon_e.addr));
          chk("rf_data", 32'(bus.rf_data), 32'(mon_e.data));
        end
      end
      if (bus.dm_req && bus.dm_ack) begin
        if (dm_q.size() == 0) chk("dm_unexpected_ack", 32'd1, 32'd0);
        else begin
          mon_e = dm_q.pop_front();
          chk("dm_addr", 32'(bus.dm_addr), 32'(mon_e.addr));
          chk("dm_data", 32'(bus.dm_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    int  n;
    int  base;
    logic strobe;

    vecs[0] = '{2'b00, 4'h3, 8'h11, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{2'b11, 4'h9, 8'h5A, 1'b0, 1'b1, 8'd0};
    vecs[2] = '{2'b01, 4'h2, 8'hFF, 1'b0, 1'b0, 8'd1};
    vecs[3] = '{2'b10, 4'hF, 8'h00, 1'b0, 1'b0, 8'd2};
    vecs[4] = '{2'b00, 4'hF, 8'hFF, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{2'b11, 4'h0, 8'h01, 1'b0, 1'b1, 8'd2};

    bus.alu_valid  = 1'b0;
    bus.alu_dst    = 2'b00;
    bus.alu_addr   = '0;
    bus.alu_result = '0;
    bus.dm_ack     = 1'b0;
    bus.err_clr    = 1'b0;

    // Reset values, before any clock edge.
    #3;
    chk("rst_rf_we",     32'(bus.rf_we), 0);
    chk("rst_dm_req",    32'(bus.dm_req), 0);
    chk("rst_err",       32'(bus.err), 0);
    chk("rst_drop",      32'(bus.drop_cnt), 0);
    chk("rst_rf_addr",   32'(bus.rf_addr), 0);
    chk("rst_rf_data",   32'(bus.rf_data), 0);
    chk("rst_dm_addr",   32'(bus.dm_addr), 0);
    chk("rst_dm_data",   32'(bus.dm_data), 0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single beats from IDLE, one destination code per vector.
    foreach (vecs[i]) begin
      set_beat(vecs[i].dst, vecs[i].addr, vecs[i].data);
      if (vecs[i].dst == 2'b00) rf_q.push_back('{vecs[i].addr, vecs[i].data});
      if (vecs[i].dst == 2'b11) dm_q.push_back('{vecs[i].addr, vecs[i].data});
      tick();
      bus.alu_valid = 1'b0;
      chk($sformatf("vec%0d_rf_we", i), 32'(bus.rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_dm_req", i), 32'(bus.dm_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_drop", i), 32'(bus.drop_cnt), 32'(vecs[i].exp_drop));
      chk($sformatf("vec%0d_ready", i), 32'(bus.alu_ready), 32'(!vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
        chk($sformatf("vec%0d_dm_req_done", i), 32'(bus.dm_req), 0);
        chk($sformatf("vec%0d_ready_done", i), 32'(bus.alu_ready), 1);
      end
      tick();
    end

    // RF streaming: three back-to-back beats.
    base = rf_seen;
    for (int i = 0; i < 3; i++) begin
      set_beat(2'b00, ADDR_W'(i + 1), 8'hA1 + 8'(i));
      rf_q.push_back('{ADDR_W'(i + 1), 8'hA1 + 8'(i)});
      tick();
      chk($sformatf("stream%0d_rf_we", i), 32'(bus.rf_we), 1);
    end
    bus.alu_valid = 1'b0;
    tick();
    chk("stream_rf_we_off", 32'(bus.rf_we), 0);
    chk("stream_rf_count", 32'(rf_seen - base), 3);

    // DM write acked after 4 cycles, with an RF beat held while not ready.
    set_beat(2'b11, 4'h5, 8'h3C);
    dm_q.push_back('{4'h5, 8'h3C});
    tick();
    set_beat(2'b00, 4'h7, 8'h77);
    rf_q.push_back('{4'h7, 8'h77});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dm_c%0d_req", i), 32'(bus.dm_req), 1);
      chk($sformatf("dm_c%0d_ready", i), 32'(bus.alu_ready), 0);
      chk($sformatf("dm_c%0d_addr", i), 32'(bus.dm_addr), 32'h5);
      chk($sformatf("dm_c%0d_data", i), 32'(bus.dm_data), 32'h3C);
      chk($sformatf("dm_c%0d_err", i), 32'(bus.err), 0);
      chk($sformatf("dm_c%0d_rf_we", i), 32'(bus.rf_we), 0);
      if (i == 3) bus.dm_ack = 1'b1;
      tick();
    end
    bus.dm_ack = 1'b0;
    chk("dm_req_released", 32'(bus.dm_req), 0);
    chk("dm_ready_back", 32'(bus.alu_ready), 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("held_beat_rf_we", 32'(bus.rf_we), 1);
    tick();
    chk("held_beat_rf_we_off", 32'(bus.rf_we), 0);

    // DM timeout with err_clr held across it: the set must win.
    set_beat(2'b11, 4'hA, 8'h99);
    bus.err_clr = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    n = 0;
    while (bus.dm_req && n < 40) begin
      n++;
      tick();
    end
    bus.err_clr = 1'b0;
    chk("tmo_req_cycles", 32'(n), TMO);
    chk("tmo_err_set", 32'(bus.err), 1);
    chk("tmo_dm_addr_hold", 32'(bus.dm_addr), 32'hA);
    tick();
    chk("tmo_err_sticky", 32'(bus.err), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.err), 0);

    // Ack landing on the timeout cycle: accepted, no error.
    set_beat(2'b11, 4'hC, 8'hC3);
    dm_q.push_back('{4'hC, 8'hC3});
    tick();
    bus.alu_valid = 1'b0;
    n = 0;
    while (bus.dm_req && n < 40) begin
      n++;
      if (n == TMO) bus.dm_ack = 1'b1;
      tick();
    end
    bus.dm_ack = 1'b0;
    chk("ack_on_tmo_cycles", 32'(n), TMO);
    chk("ack_on_tmo_no_err", 32'(bus.err), 0);

    // Illegal destination flood: saturate the drop counter.
    set_beat(2'b01, 4'h1, 8'h10);
    strobe = 1'b0;
    repeat (300) begin
      tick();
      if (bus.rf_we || bus.dm_req) strobe = 1'b1;
    end
    bus.alu_valid = 1'b0;
    chk("drop_no_strobe", 32'(strobe), 0);
    chk("drop_saturated", 32'(bus.drop_cnt), 255);
    set_beat(2'b10, 4'h1, 8'h10);
    tick();
    bus.alu_valid = 1'b0;
    chk("drop_hold_255", 32'(bus.drop_cnt), 255);

    // Async reset in the middle of a DM write.
    set_beat(2'b11, 4'h6, 8'h66);
    tick();
    bus.alu_valid = 1'b0;
    tick();
    chk("pre_rst_dm_req", 32'(bus.dm_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_dm_req", 32'(bus.dm_req), 0);
    chk("async_rst_ready", 32'(bus.alu_ready), 1);
    chk("async_rst_drop", 32'(bus.drop_cnt), 0);
    chk("async_rst_dm_addr", 32'(bus.dm_addr), 0);
    tick();
    rst_n = 1'b1;
    bus.dm_ack = 1'b1;
    tick();
    tick();
    chk("late_ack_dm_req", 32'(bus.dm_req), 0);
    chk("late_ack_ready", 32'(bus.alu_ready), 1);
    chk("late_ack_err", 32'(bus.err), 0);
    bus.dm_ack = 1'b0;
    tick();

    chk("rf_q_drained", 32'(rf_q.size()), 0);
    chk("dm_q_drained", 32'(dm_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
